// File: rtl/ram_pkg.sv
// Shared definitions for the RAM DMA initiator: default widths, op and rw
// encodings, and the FSM state type.
package ram_pkg;

    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_DW = 8;

    localparam logic OP_COPY  = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } dma_state_e;

    function automatic logic is_active(input dma_state_e s);
        return (s == READ) || (s == WRITE);
    endfunction

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Address generator for the DMA initiator: holds the latched base addresses,
// length and byte counter, and produces wrapped src/dst addresses.
module ram_dma_addr_gen
    import ram_pkg::*;
#(
    parameter int unsigned AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_inc,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [AW-1:0] i_len,
    output logic [AW-1:0] o_src_addr,
    output logic [AW-1:0] o_dst_addr,
    output logic          o_last
);

    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_src <= i_src;
            r_dst <= i_dst;
            r_len <= i_len;
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Sums are truncated to AW bits, so addresses wrap modulo 2^AW.
    assign w_cnt_nxt  = r_cnt + AW'(1);
    assign o_src_addr = r_src + r_cnt;
    assign o_dst_addr = r_dst + r_cnt;
    assign o_last     = (w_cnt_nxt == r_len);

endmodule

// File: rtl/ram_dma_initiator.sv
// Block COPY/FILL DMA initiator for a single-port RAM.
// Optional RAM_DMA_SUM_EN adds a running additive checksum output `sum`.
module ram_dma_initiator
    import ram_pkg::*;
#(
    parameter int unsigned AW = RAM_AW,
    parameter int unsigned DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rw,
    output logic          ram_en,
`ifdef RAM_DMA_SUM_EN
    output logic [DW-1:0] sum,
`endif
    input  logic [DW-1:0] ram_out
);

    dma_state_e    r_state;
    dma_state_e    w_next;

    logic          r_op;
    logic [DW-1:0] r_fill;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] w_wdata;
    logic          w_accept;
    logic [AW-1:0] w_src_addr;
    logic [AW-1:0] w_dst_addr;
    logic          w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_wdata  = (r_op == OP_FILL) ? r_fill : r_hold;

    ram_dma_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_inc      (r_state == WRITE),
        .i_src      (src_addr),
        .i_dst      (dst_addr),
        .i_len      (len),
        .o_src_addr (w_src_addr),
        .o_dst_addr (w_dst_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_next = DONE;
                    end else if (op == OP_COPY) begin
                        w_next = READ;
                    end else begin
                        w_next = WRITE;
                    end
                end
            end
            READ:  w_next = WRITE;
            WRITE: begin
                if (w_last) begin
                    w_next = DONE;
                end else if (r_op == OP_COPY) begin
                    w_next = READ;
                end else begin
                    w_next = WRITE;
                end
            end
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= OP_COPY;
            r_fill <= '0;
            r_hold <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= op;
                r_fill <= fill_data;
            end
            if (r_state == READ) begin
                r_hold <= ram_out;
            end
        end
    end

`ifdef RAM_DMA_SUM_EN
    logic [DW-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_sum <= '0;
        end else if (r_state == WRITE) begin
            r_sum <= r_sum + w_wdata;
        end
    end

    assign sum = r_sum;
`endif

    // Outputs are forced idle while rst is high so the write in flight during
    // a mid-command reset never reaches the RAM.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_en   = 1'b0;
        ram_rw   = RW_READ;
        ram_addr = '0;
        ram_data = '0;
        if (!rst) begin
            busy = is_active(r_state);
            unique case (r_state)
                READ: begin
                    ram_en   = 1'b1;
                    ram_addr = w_src_addr;
                end
                WRITE: begin
                    ram_en   = 1'b1;
                    ram_rw   = RW_WRITE;
                    ram_addr = w_dst_addr;
                    ram_data = w_wdata;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma_initiator.sv
// Randomized self-checking bench for ram_dma_initiator against an array model.
module tb_ram_dma_initiator;
    import ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic [7:0] fill_data;
    logic       busy;
    logic       done;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_rw;
    logic       ram_en;
    logic [7:0] ram_out;
`ifdef RAM_DMA_SUM_EN
    logic [7:0] sum;
`endif

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ram_dma_initiator #(
        .AW (8),
        .DW (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_rw    (ram_rw),
        .ram_en    (ram_en),
`ifdef RAM_DMA_SUM_EN
        .sum       (sum),
`endif
        .ram_out   (ram_out)
    );

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en && ram_rw == RW_WRITE) begin
            mem[ram_addr] <= ram_data;
        end
    end

    assign ram_out = (ram_en && ram_rw == RW_READ) ? mem[ram_addr] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_mem(input string tag);
        int nbad;
        nbad = 0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                if (nbad == 0) begin
                    $display("  first differing byte at %0h: %0h vs model %0h", a, mem[a], ref_mem[a]);
                end
                nbad++;
            end
        end
        check(tag, nbad, 0);
    endtask

    task automatic scramble_inputs();
        op        = 1'($urandom);
        src_addr  = 8'($urandom);
        dst_addr  = 8'($urandom);
        len       = 8'($urandom);
        fill_data = 8'($urandom);
    endtask

    task automatic run_cmd(input logic op_i, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input bit poke_start);
        int         exp_done;
        int         done_at;
        int         busy_n;
        int         en_n;
        logic [7:0] es;
        logic [7:0] b;
        logic [7:0] ia;

        es = 8'h00;
        for (int i = 0; i < int'(l); i++) begin
            ia = 8'(i);
            b  = (op_i == OP_FILL) ? f : ref_mem[8'(s + ia)];
            ref_mem[8'(d + ia)] = b;
            es = es + b;
        end
        if (l == 8'd0)            exp_done = 1;
        else if (op_i == OP_FILL) exp_done = int'(l) + 1;
        else                      exp_done = 2 * int'(l) + 1;

        @(negedge clk);
        start     = 1'b1;
        op        = op_i;
        src_addr  = s;
        dst_addr  = d;
        len       = l;
        fill_data = f;
        @(posedge clk);
        #1 start = 1'b0;
        scramble_inputs();

        done_at = 0;
        busy_n  = 0;
        en_n    = 0;
        for (int c = 1; c <= 600 && done_at == 0; c++) begin
            @(negedge clk);
            if (poke_start && c == 2) begin
                start = 1'b1;
                scramble_inputs();
            end
            if (poke_start && c == 3) start = 1'b0;
            if (busy)   busy_n++;
            if (ram_en) en_n++;
            if (done)   done_at = c;
        end
        start = 1'b0;
        check("done_latency", done_at, exp_done);
        check("busy_cycles", busy_n, exp_done - 1);
        check("en_cycles", en_n, exp_done - 1);
`ifdef RAM_DMA_SUM_EN
        check("sum_at_done", sum, es);
`endif
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
`ifdef RAM_DMA_SUM_EN
        check("sum_held", sum, es);
`endif
        check_mem("mem_contents");
    endtask

    task automatic reset_mid_fill();
        logic [7:0] f;
        int         ndone;
        f = 8'($urandom);
        ref_mem[0] = f;
        @(negedge clk);
        start = 1'b1; op = OP_FILL; dst_addr = 8'h00; len = 8'd8; fill_data = f;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef RAM_DMA_SUM_EN
        check("rst_sum", sum, 8'h00);
`endif
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || ram_en) ndone++;
            @(negedge clk);
        end
        check("rst_no_done_no_access", ndone, 0);
        check_mem("rst_mem");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        op = 1'b0; src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ram_en", ram_en, 1'b0);
        check("reset_ram_rw", ram_rw, 1'b1);
        check("reset_ram_addr", ram_addr, 8'h00);
        check("reset_ram_data", ram_data, 8'h00);
`ifdef RAM_DMA_SUM_EN
        check("reset_sum", sum, 8'h00);
`endif

        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        run_cmd(OP_COPY, 8'h10, 8'h80, 8'd4, 8'h00, 1'b0);
        check("copy_byte3", mem[8'h83], 8'hD4);
        run_cmd(OP_FILL, 8'h00, 8'h20, 8'd3, 8'h5A, 1'b0);
        run_cmd(OP_FILL, 8'h00, 8'hFE, 8'd4, 8'h33, 1'b0);
        check("wrap_byte01", mem[8'h01], 8'h33);
        run_cmd(OP_COPY, 8'h30, 8'h31, 8'd0, 8'h00, 1'b0);
        run_cmd(OP_FILL, 8'h30, 8'h31, 8'd0, 8'hEE, 1'b0);
        poke(8'h40, 8'h77);
        run_cmd(OP_COPY, 8'h40, 8'h41, 8'd3, 8'h00, 1'b1);
        check("overlap_byte43", mem[8'h43], 8'h77);
        poke(8'h50, 8'h10); poke(8'h51, 8'h20); poke(8'h52, 8'h30);
        run_cmd(OP_COPY, 8'h50, 8'h90, 8'd3, 8'h00, 1'b0);
`ifdef RAM_DMA_SUM_EN
        check("sum_directed", sum, 8'h60);
`endif
        reset_mid_fill();

        run_cmd(OP_COPY, 8'($urandom), 8'($urandom), 8'd255, 8'h00, 1'b1);
        run_cmd(OP_FILL, 8'h00, 8'($urandom), 8'd200, 8'($urandom), 1'b1);
        for (int n = 0; n < 24; n++) begin
            logic       o;
            logic [7:0] l;
            bit         p;
            o = 1'($urandom);
            l = 8'($urandom_range(0, 12));
            p = ($urandom_range(0, 1) == 1) && (l != 8'd0) && (o == OP_COPY || l >= 8'd2);
            run_cmd(o, 8'($urandom), 8'($urandom), l, 8'($urandom), p);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
